// File: rtl/lfsr_rand_range.sv
// Parametrised Fibonacci LFSR with seed loading, lock-up protection and a
// rejection-sampling draw engine returning a uniform value in [0, limit).
module lfsr_rand_range #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] TAPS          = 8'h88,
  parameter bit               FEEDBACK_XNOR = 1'b1,
  parameter int unsigned      MAX_TRIES     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_out
);

  localparam int unsigned      CW       = $clog2(MAX_TRIES + 1);
  localparam logic [CW-1:0]    LAST_TRY = CW'(MAX_TRIES - 1);
  localparam logic [WIDTH-1:0] RV       = FEEDBACK_XNOR ? '0 : WIDTH'(1);
  localparam logic [WIDTH-1:0] LOCKUP   = FEEDBACK_XNOR ? '1 : '0;

  typedef enum logic {IDLE, DRAW} fsm_t;

  fsm_t             fsm;
  logic [CW-1:0]    tries;
  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] mask;

  logic             fb;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] seed_safe;
  logic [WIDTH-1:0] lim_m1;
  logic [WIDTH-1:0] mask_c;
  logic [WIDTH-1:0] cand;
  logic             accept;

  always_comb begin
    fb        = (^(out & TAPS)) ^ FEEDBACK_XNOR;
    step_val  = {out[WIDTH-2:0], fb};
    seed_safe = (seed == LOCKUP) ? RV : seed;
    // Smear the highest set bit of limit-1 downwards; limit=0 wraps to all-ones.
    lim_m1    = limit - 1'b1;
    mask_c    = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      mask_c[i] = |(lim_m1 >> i);
    cand      = out & mask;
    accept    = (lim == '0) || (cand < lim);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= RV;
      busy      <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
      fsm       <= IDLE;
      tries     <= '0;
      lim       <= '0;
      mask      <= '0;
    end else begin
      rnd_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (req) begin
            lim   <= limit;
            mask  <= mask_c;
            tries <= '0;
            fsm   <= DRAW;
            busy  <= 1'b1;
          end
        end
        DRAW: begin
          tries <= tries + 1'b1;
          if (accept) begin
            rnd_out   <= cand;
            rnd_valid <= 1'b1;
            fsm       <= IDLE;
            busy      <= 1'b0;
          end else if (tries == LAST_TRY) begin
            // mask < 2*limit, so a single subtraction folds into range
            rnd_out   <= cand - lim;
            rnd_valid <= 1'b1;
            fsm       <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase

      if (seed_load)
        out <= seed_safe;
      else if (fsm == DRAW || req || enable)
        out <= step_val;
    end
  end

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Directed bench for lfsr_rand_range: default XNOR instance, a MAX_TRIES=2
// instance sharing its stimulus, and a 4-bit XOR instance.
module tb_lfsr_rand_range;

  logic       clk = 1'b0;
  logic       reset, enable, seed_load, req;
  logic [7:0] seed, limit;
  logic [7:0] out_a, rnd_out_a, out_b, rnd_out_b;
  logic       busy_a, rnd_valid_a, busy_b, rnd_valid_b;

  logic       enable_c, seed_load_c, req_c;
  logic [3:0] seed_c, limit_c, out_c, rnd_out_c;
  logic       busy_c, rnd_valid_c;

  int errors = 0;
  int checks = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  lfsr_rand_range dut_a (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .req(req), .limit(limit), .out(out_a), .busy(busy_a), .rnd_valid(rnd_valid_a),
    .rnd_out(rnd_out_a)
  );

  lfsr_rand_range #(.MAX_TRIES(2)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
    .req(req), .limit(limit), .out(out_b), .busy(busy_b), .rnd_valid(rnd_valid_b),
    .rnd_out(rnd_out_b)
  );

  lfsr_rand_range #(.WIDTH(4), .TAPS(4'hC), .FEEDBACK_XNOR(1'b0)) dut_c (
    .clk(clk), .reset(reset), .enable(enable_c), .seed_load(seed_load_c), .seed(seed_c),
    .req(req_c), .limit(limit_c), .out(out_c), .busy(busy_c), .rnd_valid(rnd_valid_c),
    .rnd_out(rnd_out_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rnd_valid pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rnd_valid_a) begin
      checks++;
      assert (q_a.size() != 0) else begin
        errors++;
        $error("FAIL rnd_a_unexpected observed=%0h expected=none", rnd_out_a);
      end
      if (q_a.size() != 0) chk("rnd_out_a", rnd_out_a, q_a.pop_front());
    end
    if (rnd_valid_b) begin
      checks++;
      assert (q_b.size() != 0) else begin
        errors++;
        $error("FAIL rnd_b_unexpected observed=%0h expected=none", rnd_out_b);
      end
      if (q_b.size() != 0) chk("rnd_out_b", rnd_out_b, q_b.pop_front());
    end
  end

  task automatic load_seed(input logic [7:0] s);
    seed = s; seed_load = 1'b1;
    step_clk();
    seed_load = 1'b0;
  endtask

  task automatic run_draw(input logic [7:0] s, input logic [7:0] lim,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input int la, input int lb, input int ba);
    int lat_a, lat_b, bcnt, vcnt;
    load_seed(s);
    req = 1'b1; limit = lim;
    q_a.push_back(ea); q_b.push_back(eb);
    step_clk();
    req = 1'b0;
    lat_a = 0; lat_b = 0; vcnt = 0;
    bcnt = int'(busy_a);
    for (int n = 1; n <= 20; n++) begin
      step_clk();
      if (rnd_valid_a && lat_a == 0) lat_a = n;
      if (rnd_valid_b && lat_b == 0) lat_b = n;
      bcnt += int'(busy_a);
      vcnt += int'(rnd_valid_a);
    end
    chk($sformatf("lat_a_lim%0d", lim), lat_a, la);
    chk($sformatf("lat_b_lim%0d", lim), lat_b, lb);
    chk($sformatf("busy_cycles_a_lim%0d", lim), bcnt, ba);
    chk($sformatf("valid_pulses_a_lim%0d", lim), vcnt, 1);
  endtask

  initial begin
    logic [7:0] seq [6];
    logic [3:0] m, start;
    logic [15:0] seen;
    int vcnt, vpos;
    seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C};

    reset = 1'b1; enable = 1'b0; seed_load = 1'b0; req = 1'b0; seed = '0; limit = '0;
    enable_c = 1'b0; seed_load_c = 1'b0; req_c = 1'b0; seed_c = '0; limit_c = '0;
    step_clk();
    step_clk();
    chk("reset_out_a", out_a, 8'h00);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_valid_a", rnd_valid_a, 0);
    chk("reset_rnd_out_a", rnd_out_a, 8'h00);
    chk("reset_out_c", out_c, 4'h1);
    chk("reset_busy_c", busy_c, 0);
    chk("reset_valid_c", rnd_valid_c, 0);
    chk("reset_rnd_out_c", rnd_out_c, 4'h0);

    reset = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_clk();
      chk($sformatf("seq_%0d", i), out_a, seq[i]);
    end
    enable = 1'b0;
    step_clk();
    step_clk();
    chk("hold_out_a", out_a, 8'h3C);

    load_seed(8'hFF);
    chk("seed_lockup_guard", out_a, 8'h00);
    load_seed(8'h5A);
    chk("seed_5a", out_a, 8'h5A);
    enable = 1'b1;
    load_seed(8'h11);
    chk("seed_beats_enable", out_a, 8'h11);
    enable = 1'b0;

    // seed, limit, exp_a, exp_b, lat_a, lat_b, busy cycles of dut_a
    run_draw(8'h03, 8'd6, 8'd4, 8'd1, 4, 2, 4);
    run_draw(8'h03, 8'd1, 8'd0, 8'd0, 1, 1, 1);
    run_draw(8'h03, 8'd0, 8'h07, 8'h07, 1, 1, 1);

    // req held: dut_a completes at k+4 and restarts at k+5; dut_b completes at k+2 and k+4
    load_seed(8'h03);
    req = 1'b1; limit = 8'd6;
    q_a.push_back(8'd4);
    q_b.push_back(8'd1); q_b.push_back(8'd4);
    step_clk();
    vcnt = 0; vpos = 0;
    for (int n = 1; n <= 5; n++) begin
      step_clk();
      if (rnd_valid_a) begin vcnt++; vpos = n; end
    end
    chk("held_req_valid_count_a", vcnt, 1);
    chk("held_req_valid_pos_a", vpos, 4);
    chk("held_req_restart_busy_a", busy_a, 1);
    reset = 1'b1; req = 1'b0;
    step_clk();
    chk("midreset_busy_a", busy_a, 0);
    chk("midreset_busy_b", busy_b, 0);
    chk("midreset_out_a", out_a, 8'h00);
    reset = 1'b0;
    vcnt = int'(rnd_valid_a);
    for (int n = 0; n < 4; n++) begin
      step_clk();
      vcnt += int'(rnd_valid_a);
    end
    chk("midreset_no_valid_a", vcnt, 0);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);

    // 4-bit XOR instance: x^4+x^3+1 visits all 15 nonzero states
    enable_c = 1'b1;
    start = out_c;
    m = start;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      step_clk();
      m = {m[2:0], m[3] ^ m[2]};
      chk($sformatf("xor_seq_%0d", i), out_c, m);
      seen[out_c] = 1'b1;
    end
    chk("xor_all_nonzero_states", seen, 16'hFFFE);
    chk("xor_period_15", out_c, start);
    enable_c = 1'b0;
    seed_c = 4'h0; seed_load_c = 1'b1;
    step_clk();
    seed_load_c = 1'b0;
    chk("xor_seed_lockup_guard", out_c, 4'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
